// File: rtl/tensor_tile_buf.sv
// Tile buffer between the read-DMA and write-DMA streams: FIFO-backed transfer of cfg_beats beats,
// cut-through or store-and-forward. Optional stall counters when TILE_BUF_STAT_EN is defined.
module tensor_tile_buf #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           cfg_beats,
    input  logic                       cfg_mode,
    input  logic                       cfg_start,
    output logic                       cfg_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    input  logic [DATA_W-1:0]          s_dat,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [DATA_W-1:0]          m_dat,
    output logic                       m_valid,
    input  logic                       m_ready
`ifdef TILE_BUF_STAT_EN
    ,
    output logic [CNT_W-1:0]           stall_in,
    output logic [CNT_W-1:0]           stall_out
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    // Handshakes: a beat moves on a cycle where valid && ready; valid never drops before ready.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_q;
    logic [CNT_W-1:0]  beats_q, in_cnt, out_cnt;
    logic              mode_q;
    logic              push, pop, start_acc, last_pop, release_ok;

    assign level = level_q;
    assign m_dat = mem[rd_ptr];

    // Store-and-forward holds the tile until complete, or releases on full to avoid deadlock.
    assign release_ok = !mode_q || (in_cnt == beats_q) || (level_q == FULL);
    assign s_ready    = (state == S_RUN) && (in_cnt < beats_q) && (level_q < FULL);
    assign m_valid    = (state == S_RUN) && (level_q != '0) && release_ok;
    assign push       = s_valid && s_ready;
    assign pop        = m_valid && m_ready;
    assign last_pop   = pop && (out_cnt == beats_q - CNT_W'(1));
    assign start_acc  = (state == S_IDLE) && cfg_start;

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        cfg_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) state_nxt = (cfg_beats == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (last_pop) state_nxt = S_DONE;
            end
            S_DONE: begin
                cfg_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            beats_q <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            mode_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                beats_q <= cfg_beats;
                mode_q  <= cfg_mode;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (push) begin
                    in_cnt <= in_cnt + CNT_W'(1);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    out_cnt <= out_cnt + CNT_W'(1);
                    rd_ptr  <= rd_ptr + AW'(1);
                end
                level_q <= level_q + LW'(push) - LW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_dat;
    end

`ifdef TILE_BUF_STAT_EN
    logic [CNT_W-1:0] stall_in_q, stall_out_q;
    assign stall_in  = stall_in_q;
    assign stall_out = stall_out_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else if (state == S_RUN) begin
            if (s_valid && !s_ready && stall_in_q != '1)  stall_in_q  <= stall_in_q + CNT_W'(1);
            if (m_valid && !m_ready && stall_out_q != '1) stall_out_q <= stall_out_q + CNT_W'(1);
        end
    end
`endif

endmodule
